// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad front end.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM state enum, output codes, key map and row-pattern helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    REPORT   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [3:0] KEY_ERR   = 4'hA;
  localparam logic [3:0] KEY_BLANK = 4'hF;
  localparam logic [2:0] MAX_PRESS = 3'd4;

  // Key face labels indexed by {row, col}; entry 0 is row0/col0.
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: 0 F E D
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // True when exactly one active-low row is pulled low.
  function automatic logic single_low(input logic [3:0] p);
    logic [3:0] n;
    n = ~p;
    return (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
  endfunction

  // Index of the low row in a single-low pattern.
  function automatic logic [1:0] low_index(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!p[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Maps a {row, col} key position to its 4-bit code plus digit/clear flags.
// Latency: combinational. Backpressure: none.
// Optional KEYPAD_CLEAR_KEY_EN turns key C into a clear key (code KEY_BLANK).
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [1:0] row_idx_i,
  input  logic [1:0] col_idx_i,
  output logic [3:0] code_o,
  output logic       is_digit_o,
  output logic       is_clear_o
);

  logic [3:0] label;

  // Look up the key face, then fold non-digits onto the error or blank code.
  always_comb begin
    label      = KEY_MAP[{row_idx_i, col_idx_i}];
    is_digit_o = (label <= 4'd9);
`ifdef KEYPAD_CLEAR_KEY_EN
    is_clear_o = (label == 4'hC);
`else
    is_clear_o = 1'b0;
`endif
    if (is_digit_o) begin
      code_o = label;
    end else if (is_clear_o) begin
      code_o = KEY_BLANK;
    end else begin
      code_o = KEY_ERR;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces one key, reports it as a 1-cycle strobe.
// Latency: key_valid DEBOUNCE_CYC+1 cycles after the detecting sample edge.
// Backpressure: none; consumer must take key_val/press_count on the strobe.
// Build option KEYPAD_CLEAR_KEY_EN (see keypad_decode) makes key C clear the entry.
module keypad_scanner #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_val,
  output logic [2:0] press_count,
  output logic       key_valid
);
  import keypad_pkg::*;

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);

  logic [3:0]    sync1_q, rs_q;
  state_t        state_q, state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    col_q;
  logic [3:0]    key_val_q, key_val_d;
  logic [2:0]    press_count_q, press_count_d;
  logic          key_valid_q, key_valid_d;

  logic [3:0]    dec_code;
  logic          dec_digit;
  logic          dec_clear;

  // Column and latched row are held from detection through WAIT_REL, so the
  // decoder sees a stable key position when REPORT fires.
  keypad_decode u_decode (
    .row_idx_i  (row_idx_q),
    .col_idx_i  (col_idx_q),
    .code_o     (dec_code),
    .is_digit_o (dec_digit),
    .is_clear_o (dec_clear)
  );

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'hF;
      rs_q    <= 4'hF;
    end else begin
      sync1_q <= row;
      rs_q    <= sync1_q;
    end
  end

  // Scan / debounce / report / release FSM and output next-state.
  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    cnt_d         = cnt_q;
    pat_d         = pat_q;
    row_idx_d     = row_idx_q;
    key_val_d     = key_val_q;
    press_count_d = press_count_q;
    key_valid_d   = 1'b0;
    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (single_low(rs_q)) begin
            pat_d     = rs_q;
            row_idx_d = low_index(rs_q);
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DEBOUNCE: begin
        // Any deviation (release, bounce, extra row) abandons this key.
        if (rs_q != pat_q) begin
          state_d   = SCAN;
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
        end else if (cnt_q == DEB_LAST) begin
          state_d = REPORT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPORT: begin
        key_valid_d = 1'b1;
        key_val_d   = dec_code;
        if (dec_clear) begin
          press_count_d = 3'd0;
        end else if (dec_digit) begin
          // A fifth digit starts a fresh entry rather than saturating.
          press_count_d = (press_count_q == MAX_PRESS) ? 3'd1 : press_count_q + 3'd1;
        end
        state_d = WAIT_REL;
        cnt_d   = '0;
      end
      WAIT_REL: begin
        if (rs_q != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = SCAN;
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SCAN;
      col_idx_q     <= 2'd0;
      cnt_q         <= '0;
      pat_q         <= 4'hF;
      row_idx_q     <= 2'd0;
      col_q         <= 4'b1110;
      key_val_q     <= KEY_BLANK;
      press_count_q <= 3'd0;
      key_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      cnt_q         <= cnt_d;
      pat_q         <= pat_d;
      row_idx_q     <= row_idx_d;
      col_q         <= ~(4'b0001 << col_idx_d);
      key_val_q     <= key_val_d;
      press_count_q <= press_count_d;
      key_valid_q   <= key_valid_d;
    end
  end

  assign col         = col_q;
  assign key_val     = key_val_q;
  assign press_count = press_count_q;
  assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYC=8.
// A behavioural keypad matrix drives row from col and the pressed-key map.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_val;
  logic [2:0]  press_count;
  logic        key_valid;

  logic [15:0] keys;        // pressed keys, index {row, col}
  int          n_checks;
  int          n_errors;
  int          nstrobe;
  logic [3:0]  last_val;
  logic [2:0]  last_cnt;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .key_val     (key_val),
    .press_count (press_count),
    .key_valid   (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its (driven-low) column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Strobe monitor, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (key_valid) begin
      nstrobe++;
      last_val = key_val;
      last_cnt = press_count;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    keys  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Wait for the strobe, check it, hold the key, release and confirm one strobe only.
  task automatic finish_press(input string tag, input logic [3:0] ev, input logic [2:0] ec,
                              input int s0);
    int t;
    t = 0;
    while (nstrobe == s0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_val"}, 32'(last_val), 32'(ev));
    check({tag, "_cnt"}, 32'(last_cnt), 32'(ec));
    repeat (20) @(negedge clk);
    keys = '0;
    repeat (30) @(negedge clk);
    check({tag, "_strobes"}, 32'(nstrobe - s0), 32'd1);
  endtask

  task automatic press_key(input string tag, input int idx, input logic [3:0] ev,
                           input logic [2:0] ec);
    int s0;
    s0 = nstrobe;
    keys = '0;
    keys[idx] = 1'b1;
    finish_press(tag, ev, ec, s0);
  endtask

  initial begin
    int s0;
    int run;
    int lat;
    logic [3:0] mask;
    n_checks = 0;
    n_errors = 0;
    nstrobe  = 0;
    last_val = 4'h0;
    last_cnt = 3'd0;
    keys     = '0;
    rst_n    = 1'b0;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("reset_col", 32'(col), 32'hE);
    check("reset_key_val", 32'(key_val), 32'hF);
    check("reset_press_count", 32'(press_count), 32'd0);
    check("reset_key_valid", 32'(key_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single press of key 5 (r1, c1), held well past the strobe.
    press_key("single5", 5, 4'h5, 3'd1);

    // Reset in the middle of debouncing key 1 (r0, c0): col stuck at 1110 for
    // 6 cycles means the key was detected and debounce is running.
    keys = '0;
    keys[0] = 1'b1;
    run = 0;
    for (int i = 0; i < 100 && run < 6; i++) begin
      @(negedge clk);
      if (col == 4'b1110) run++;
      else run = 0;
    end
    check("rst_reach_debounce", 32'(run), 32'd6);
    s0 = nstrobe;
    rst_n = 1'b0;
    #1;
    check("rst_mid_col", 32'(col), 32'hE);
    check("rst_mid_key_val", 32'(key_val), 32'hF);
    check("rst_mid_press_count", 32'(press_count), 32'd0);
    check("rst_mid_key_valid", 32'(key_valid), 32'd0);
    repeat (4) @(negedge clk);
    check("rst_discard", 32'(nstrobe - s0), 32'd0);
    // Key still held: 4 scan cycles to the sample edge, then 8+1 to the strobe.
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      @(posedge clk);
      #2;
      if (key_valid) lat = i;
    end
    check("rst_latency", 32'(lat), 32'd13);
    check("rst_held_val", 32'(key_val), 32'h1);
    check("rst_held_cnt", 32'(press_count), 32'd1);
    repeat (10) @(negedge clk);
    keys = '0;
    repeat (30) @(negedge clk);
    check("rst_held_strobes", 32'(nstrobe - s0), 32'd1);

    // Bounce on key 1: 3-cycle low/high toggling must never be reported.
    s0 = nstrobe;
    keys = '0;
    for (int i = 0; i < 12; i++) begin
      keys[0] = ~keys[0];
      repeat (3) @(negedge clk);
    end
    check("bounce_quiet", 32'(nstrobe - s0), 32'd0);
    keys[0] = 1'b1;
    finish_press("bounce", 4'h1, 3'd2, s0);

    // Count wrap: 1,2,3,4,7 then error key A.
    do_reset();
    press_key("wrap_1", 0, 4'h1, 3'd1);
    press_key("wrap_2", 1, 4'h2, 3'd2);
    press_key("wrap_3", 2, 4'h3, 3'd3);
    press_key("wrap_4", 4, 4'h4, 3'd4);
    press_key("wrap_7", 8, 4'h7, 3'd1);
    press_key("err_A", 3, 4'hA, 3'd1);

    // Two rows low in column 2 (keys 3 and 9): ignored, scanning continues.
    s0 = nstrobe;
    keys = '0;
    keys[2]  = 1'b1;
    keys[10] = 1'b1;
    mask = 4'h0;
    repeat (60) begin
      @(negedge clk);
      mask = mask | ~col;
    end
    check("multi_quiet", 32'(nstrobe - s0), 32'd0);
    check("multi_scan_cols", 32'(mask), 32'hF);
    keys[2] = 1'b0;
    finish_press("multi_9", 4'h9, 3'd2, s0);

    // Key C (r2, c3).
`ifdef KEYPAD_CLEAR_KEY_EN
    press_key("clear_C", 11, 4'hF, 3'd0);
`else
    press_key("clear_C", 11, 4'hA, 3'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
